keypad_matrix_emulator: RTL and testbench

Emulates a 4x4 membrane keypad from the matrix side. It samples the column drive from the keypad scanner and drives the row lines back, as the physical switches would. A host (testbench harness, or a second FPGA's control logic) requests one key press at a time through a valid/ready handshake. The block holds the contact closed for a programmed time, then releases it and observes a gap. It is used for hardware-in-loop and system-level regression of the keypad scan/decode/display path.

---
 rtl/keypad_matrix_emulator.sv | 185 ++++++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: plays the part of a 4x4 membrane keypad toward a
// row/column scanner. A host asks for one key press at a time through
// valid/ready. The block closes the contact, holds it, releases it and waits
// out a gap before it takes the next request.
// Optional contact bounce on make/break edges: define KEYPAD_EMU_BOUNCE_EN.
module keypad_matrix_emulator #(
  parameter int HOLD_CYCLES    = 2700000,
  parameter int GAP_CYCLES     = 1350000,
  parameter int BOUNCE_PERIOD  = 27000,
  parameter int BOUNCE_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic       release_now,
  output logic       busy,
  output logic       done,
  output logic       contact,
  output logic [7:0] scan_hits
);

  localparam int HOLD_N = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_N  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BP_N   = (BOUNCE_PERIOD < 1) ? 1 : BOUNCE_PERIOD;
  localparam int BT_N   = (BOUNCE_TOGGLES < 2) ? 2 : BOUNCE_TOGGLES;
  localparam int EDGE_N = BP_N * BT_N;
  localparam int BW     = (BP_N > 1) ? $clog2(BP_N) : 1;
  localparam logic [BW-1:0] BP_LD = BW'(BP_N - 1);
`else
  // Clean edges: MAKE/BREAK last one cycle; the bounce parameters only
  // appear here so they stay referenced.
  localparam int EDGE_N = 1 + 0 * (BOUNCE_PERIOD + BOUNCE_TOGGLES);
`endif
  localparam int MAX_HG = (HOLD_N > GAP_N) ? HOLD_N : GAP_N;
  localparam int MAX_N  = (MAX_HG > EDGE_N) ? MAX_HG : EDGE_N;
  // Counter holds N-1 down to 0, so clog2(MAX_N) bits suffice.
  localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_N - 1);
  localparam logic [CW-1:0] EDGE_LD = CW'(EDGE_N - 1);

  // LATCH is the cycle right after accept: the key is registered, outputs
  // already show busy, and MAKE starts on the following edge.
  typedef enum logic [2:0] {
    IDLE, LATCH, MAKE, HOLD, BREAK, GAP
  } state_t;

  state_t          state;
  logic [3:0]      key;
  logic [CW-1:0]   cnt;
  logic            accept;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [BW-1:0]   bcnt;
`endif

  assign accept = req_valid & req_ready;

  // Row lines: pull the held key's row low only while its column is driven low
  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (contact && (key[3:2] == r[1:0]) && !columnas[key[1:0]])
        filas[r] = 1'b0;
    end
  end

  // Saturating count of cycles the scanner saw the closed contact
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scan_hits <= 8'd0;
    else if (accept)
      scan_hits <= 8'd0;
    else if (contact && !columnas[key[1:0]] && (scan_hits != 8'hFF))
      scan_hits <= scan_hits + 8'd1;
  end

  // Press sequencer: accept -> make -> hold -> break -> gap -> idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key       <= 4'd0;
      cnt       <= '0;
      contact   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bcnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key       <= req_key;
            state     <= LATCH;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          state <= MAKE;
          cnt   <= EDGE_LD;
`ifdef KEYPAD_EMU_BOUNCE_EN
          contact <= 1'b1;
          bcnt    <= BP_LD;
`endif
        end
        MAKE: begin
          if (cnt == '0) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            contact <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (bcnt == '0) begin
              contact <= ~contact;
              bcnt    <= BP_LD;
            end else begin
              bcnt <= bcnt - 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          // Early release and natural expiry share one exit, so both
          // together still give a single BREAK.
          if ((cnt == '0) || release_now) begin
            state   <= BREAK;
            cnt     <= EDGE_LD;
            contact <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bcnt    <= BP_LD;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BREAK: begin
          if (cnt == '0) begin
            state   <= GAP;
            cnt     <= GAP_LD;
            contact <= 1'b0;
            done    <= (GAP_N == 1);
          end else begin
            cnt <= cnt - 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (bcnt == '0) begin
              contact <= ~contact;
              bcnt    <= BP_LD;
            end else begin
              bcnt <= bcnt - 1'b1;
            end
`endif
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else begin
            cnt  <= cnt - 1'b1;
            // done is registered, so raise it one edge before the last cycle
            done <= (cnt == CW'(1));
          end
        end
        default: begin
          state     <= IDLE;
          contact   <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator. Stimulus pushes the expected
// per-press result; a monitor pops it when done pulses.
module tb_keypad_matrix_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int H = 300;   // long hold so scan_hits reaches saturation
`else
  localparam int H = 20;
`endif
  localparam int G = 10;
  localparam int P = 2;
  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       release_now;
  logic       busy;
  logic       done;
  logic       contact;
  logic [7:0] scan_hits;

  keypad_matrix_emulator #(
    .HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T)
  ) dut (
    .clk(clk), .rst(rst), .columnas(columnas), .filas(filas),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .release_now(release_now), .busy(busy), .done(done),
    .contact(contact), .scan_hits(scan_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         lat;    // clk edges from accept edge to the done cycle
    int         ccnt;   // cycles with contact=1
    logic [3:0] fil;    // filas in the last contact cycle
    logic [7:0] hits;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic       mon_act = 1'b0;
  int         mcyc, mcc;
  logic [3:0] mkey, mfil;

  always @(posedge rst) mon_act = 1'b0;

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) begin
      mon_act = 1'b1; mcyc = 0; mcc = 0; mkey = req_key; mfil = 4'hF;
    end else if (mon_act) begin
      mcyc++;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      mon_act = 1'b0;
    end else if (mon_act) begin
      if (contact) begin
        mcc++;
        mfil = filas;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_key", mkey, e.key);
          check("sb_latency", mcyc, e.lat);
          check("sb_contact_cycles", mcc, e.ccnt);
          check("sb_filas", mfil, e.fil);
          check("sb_scan_hits", scan_hits, e.hits);
        end
        mon_act = 1'b0;
      end
    end else if (done) begin
      check("spurious_done", 1, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] k, input logic [3:0] cols);
    @(negedge clk);
    req_valid = 1'b1; req_key = k; columnas = cols;
    @(negedge clk);
    req_valid = 1'b0;   // now mid cycle 0 (just after the accept edge)
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (!req_ready && n < 2000) begin
      @(negedge clk); n++; #1;
    end
    if (!req_ready) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  function automatic logic bounce_c(input int k);
    if (k >= 1 && k <= 8)    return (((k - 1) / 2) % 2) == 0;
    if (k >= 9 && k <= 308)  return 1'b1;
    if (k >= 309 && k <= 316) return (((k - 309) / 2) % 2) == 1;
    return 1'b0;
  endfunction

  localparam logic [3:0] SWEEP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    rst = 1'b0; columnas = 4'hF; req_valid = 1'b0; req_key = 4'h0;
    release_now = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_filas", filas, 4'hF);
    check("rst_contact", contact, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hits", scan_hits, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

`ifndef KEYPAD_EMU_BOUNCE_EN
    // Test 1: async reset mid-HOLD
    press(4'b0110, 4'b1011);
    for (int k = 1; k <= 8; k++) @(negedge clk);
    #1;
    check("t1_filas_held", filas, 4'b1101);
    check("t1_contact_held", contact, 1);
    #2 rst = 1'b1;
    #1;
    check("t1_filas", filas, 4'hF);
    check("t1_contact", contact, 0);
    check("t1_busy", busy, 0);
    check("t1_ready", req_ready, 1);
    check("t1_hits", scan_hits, 0);
    @(negedge clk); rst = 1'b0; columnas = 4'hF;
    @(negedge clk);

    // Test 2: column sweep, key row2/col1
    sbq.push_back('{key: 4'b1001, lat: 32, ccnt: 20, fil: 4'b1011, hits: 8'd5});
    @(negedge clk);
    req_valid = 1'b1; req_key = 4'b1001;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      columnas = SWEEP[k % 4];
      #1;
      check("t2_filas", filas,
            ((k >= 2) && (k <= 21) && (k % 4 == 1)) ? 4'b1011 : 4'hF);
      if (k == 32) check("t2_ready_low", req_ready, 0);
      if (k == 33) check("t2_ready_back", req_ready, 1);
    end
    columnas = 4'hF;
    @(negedge clk);

    // Test 3: request held while busy, second key waits for ready
    sbq.push_back('{key: 4'b0110, lat: 32, ccnt: 20, fil: 4'b1101, hits: 8'd20});
    sbq.push_back('{key: 4'b1100, lat: 32, ccnt: 20, fil: 4'b0111, hits: 8'd20});
    @(negedge clk);
    req_valid = 1'b1; req_key = 4'b0110; columnas = 4'h0;
    @(negedge clk);
    req_key = 4'b1100;
    #1 check("t3_ready_drop", req_ready, 0);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk); n++; #1;
      end while (!req_ready && n < 100);
      check("t3_ready_return", n, 33);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("t3_second_accept", req_ready, 0);
    check("t3_busy", busy, 1);
    wait_idle();

    // Test 4: early release 5 cycles into HOLD
    sbq.push_back('{key: 4'b0111, lat: 17, ccnt: 5, fil: 4'b1101, hits: 8'd5});
    press(4'b0111, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        release_now = 1'b1;
        #1 check("t4_contact_pre", contact, 1);
      end
      if (k == 7) begin
        release_now = 1'b0;
        #1 check("t4_contact_post", contact, 0);
      end
    end
    wait_idle();

    // Test 5: all columns low, then all high
    sbq.push_back('{key: 4'b0011, lat: 32, ccnt: 20, fil: 4'hF, hits: 8'd4});
    press(4'b0011, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) #1 check("t5_all_low", filas, 4'b1110);
      if (k == 6) begin
        columnas = 4'hF;
        #1 check("t5_all_high", filas, 4'hF);
      end
    end
    wait_idle();
`else
    // Test 6: bounce pattern on make and break, saturating scan_hits
    sbq.push_back('{key: 4'b0000, lat: 326, ccnt: 308, fil: 4'b1110, hits: 8'd255});
    press(4'b0000, 4'h0);
    for (int k = 1; k <= 326; k++) begin
      @(negedge clk);
      #1 check("t6_contact", contact, bounce_c(k));
    end
    wait_idle();
    check("t6_hits_hold", scan_hits, 8'd255);
`endif

    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
